lru_set_array: RTL

LRU_SET_ARRAY -- requirements
Module: lru_set_array

---
 rtl/lru_set_array_if.sv | 31 +++
 rtl/lru_set_array.sv | 116 +++++++++++
 2 files changed

// File: rtl/lru_set_array_if.sv
// lru_set_array_if: lookup/refill bus between a cache controller (master) and the LRU set array (slave).
interface lru_set_array_if #(
  parameter int TAG_WIDTH = 20,
  parameter int SET_WIDTH = 4,
  parameter int WAYS = 4
);
  localparam int WW = $clog2(WAYS);
  logic ready;
  logic lk_valid;
  logic [SET_WIDTH-1:0] lk_set;
  logic [TAG_WIDTH-1:0] lk_tag;
  logic [WAYS*TAG_WIDTH-1:0] line_tag;
  logic [WAYS-1:0] line_valid;
  logic [WAYS-1:0] line_dirty;
  logic rsp_valid;
  logic rsp_hit;
  logic [WW-1:0] rsp_way;
  logic rsp_dirty;
  logic [TAG_WIDTH-1:0] rsp_tag;
  logic fill_valid;
  logic [SET_WIDTH-1:0] fill_set;
  logic [WW-1:0] fill_way;
  modport master (
    input ready, rsp_valid, rsp_hit, rsp_way, rsp_dirty, rsp_tag,
    output lk_valid, lk_set, lk_tag, line_tag, line_valid, line_dirty, fill_valid, fill_set, fill_way
  );
  modport slave (
    output ready, rsp_valid, rsp_hit, rsp_way, rsp_dirty, rsp_tag,
    input lk_valid, lk_set, lk_tag, line_tag, line_valid, line_dirty, fill_valid, fill_set, fill_way
  );
endinterface

// File: rtl/lru_set_array.sv
// lru_set_array: per-set true-LRU stacks with 1-cycle hit/victim lookup and refill promotion.
// Optional macro LRU_INVALID_FIRST_EN: on a miss prefer the lowest-numbered invalid way.
module lru_set_array #(
  parameter int TAG_WIDTH = 20,
  parameter int SET_WIDTH = 4,
  parameter int WAYS = 4
) (
  input logic clk,
  input logic reset,
  lru_set_array_if.slave bus
);
  localparam int SETS = 2**SET_WIDTH;
  localparam int WW = $clog2(WAYS);
  typedef logic [WAYS-1:0][WW-1:0] stack_t;
  typedef enum logic {INIT, RUN} state_t;
  state_t state;
  logic [SET_WIDTH-1:0] cnt;
  stack_t stk [SETS];
  stack_t cur, lk_new, fill_base, fill_new, init_stk;
  logic hit, acc, lk_upd, fill_upd, sel_dirty;
  logic [WW-1:0] hit_way, vic, way;
  logic [TAG_WIDTH-1:0] sel_tag;
`ifdef LRU_INVALID_FIRST_EN
  logic inv;
  logic [WW-1:0] inv_way;
`endif
  // Move way w to MRU; entries above its old position slide down one slot.
  function automatic stack_t promote(input stack_t s, input logic [WW-1:0] w);
    stack_t r;
    logic f;
    r = s;
    f = 1'b0;
    for (int i = 0; i < WAYS-1; i++) begin
      f = f | (s[i] == w);
      r[i] = f ? s[i+1] : s[i];
    end
    r[WAYS-1] = w;
    return r;
  endfunction
  always_comb begin
    cur = stk[bus.lk_set];
    hit = 1'b0;
    hit_way = '0;
    init_stk = '0;
    for (int i = WAYS-1; i >= 0; i--) begin
      init_stk[i] = WW'(i);
      if (bus.line_valid[i] && bus.line_tag[i*TAG_WIDTH +: TAG_WIDTH] == bus.lk_tag) begin
        hit = 1'b1;
        hit_way = WW'(i);
      end
    end
`ifdef LRU_INVALID_FIRST_EN
    inv = 1'b0;
    inv_way = '0;
    for (int i = WAYS-1; i >= 0; i--) begin
      if (!bus.line_valid[i]) begin
        inv = 1'b1;
        inv_way = WW'(i);
      end
    end
    vic = inv ? inv_way : cur[0];
`else
    vic = cur[0];
`endif
    way = hit ? hit_way : vic;
    sel_dirty = 1'b0;
    sel_tag = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (WW'(i) == way) begin
        sel_dirty = bus.line_dirty[i];
        sel_tag = bus.line_tag[i*TAG_WIDTH +: TAG_WIDTH];
      end
    end
    acc = bus.ready && bus.lk_valid;
    lk_upd = acc && hit;
    fill_upd = bus.ready && bus.fill_valid;
    lk_new = promote(cur, hit_way);
    // A fill to the set just hit must build on the hit-updated stack.
    fill_base = (lk_upd && bus.fill_set == bus.lk_set) ? lk_new : stk[bus.fill_set];
    fill_new = promote(fill_base, bus.fill_way);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= INIT;
      cnt <= '0;
      bus.ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_hit <= 1'b0;
      bus.rsp_way <= '0;
      bus.rsp_dirty <= 1'b0;
      bus.rsp_tag <= '0;
    end else begin
      bus.rsp_valid <= acc;
      if (acc) begin
        bus.rsp_hit <= hit;
        bus.rsp_way <= way;
        bus.rsp_dirty <= sel_dirty;
        bus.rsp_tag <= sel_tag;
      end
      if (state == INIT) begin
        cnt <= cnt + 1'b1;
        if (&cnt) begin
          state <= RUN;
          bus.ready <= 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      if (state == INIT) stk[cnt] <= init_stk;
      if (lk_upd) stk[bus.lk_set] <= lk_new;
      if (fill_upd) stk[bus.fill_set] <= fill_new;
    end
  end
endmodule
